// File: rtl/spectrum_bar_scaler.sv
// spectrum_bar_scaler: log-compresses 16 FFT bin magnitudes, removes a noise floor and
// applies peak-hold with linear decay, one bin per cycle after each rising edge of done.
`default_nettype none

module spectrum_bar_scaler #(
    parameter int FLOOR = 64,
    parameter int DECAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        done,
    input  logic [23:0] f0,
    input  logic [23:0] f1,
    input  logic [23:0] f2,
    input  logic [23:0] f3,
    input  logic [23:0] f4,
    input  logic [23:0] f5,
    input  logic [23:0] f6,
    input  logic [23:0] f7,
    input  logic [23:0] f8,
    input  logic [23:0] f9,
    input  logic [23:0] f10,
    input  logic [23:0] f11,
    input  logic [23:0] f12,
    input  logic [23:0] f13,
    input  logic [23:0] f14,
    input  logic [23:0] f15,
    output logic [7:0]  h0,
    output logic [7:0]  h1,
    output logic [7:0]  h2,
    output logic [7:0]  h3,
    output logic [7:0]  h4,
    output logic [7:0]  h5,
    output logic [7:0]  h6,
    output logic [7:0]  h7,
    output logic [7:0]  h8,
    output logic [7:0]  h9,
    output logic [7:0]  h10,
    output logic [7:0]  h11,
    output logic [7:0]  h12,
    output logic [7:0]  h13,
    output logic [7:0]  h14,
    output logic [7:0]  h15,
    output logic        valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [0:0] {IDLE = 1'b0, PROC = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, armed_q;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        rise_w, capture_w, write_w;
    logic [23:0] f_w   [16];
    logic [23:0] buf_q [16];
    logic [7:0]  h_q   [16];

    logic [23:0] mag_w;
    logic [25:0] ext_w;
    logic [4:0]  msb_w;
    logic [2:0]  frac_w;
    logic [7:0]  level_w, tgt_w, cur_w, dec_w, new_w;

    assign f_w[0]  = f0;   assign f_w[1]  = f1;   assign f_w[2]  = f2;   assign f_w[3]  = f3;
    assign f_w[4]  = f4;   assign f_w[5]  = f5;   assign f_w[6]  = f6;   assign f_w[7]  = f7;
    assign f_w[8]  = f8;   assign f_w[9]  = f9;   assign f_w[10] = f10;  assign f_w[11] = f11;
    assign f_w[12] = f12;  assign f_w[13] = f13;  assign f_w[14] = f14;  assign f_w[15] = f15;

    assign h0  = h_q[0];   assign h1  = h_q[1];   assign h2  = h_q[2];   assign h3  = h_q[3];
    assign h4  = h_q[4];   assign h5  = h_q[5];   assign h6  = h_q[6];   assign h7  = h_q[7];
    assign h8  = h_q[8];   assign h9  = h_q[9];   assign h10 = h_q[10];  assign h11 = h_q[11];
    assign h12 = h_q[12];  assign h13 = h_q[13];  assign h14 = h_q[14];  assign h15 = h_q[15];

    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == PROC);

    // armed_q blocks a capture on the first edge after reset so a level-high done is ignored
    assign rise_w = done & ~done_q & armed_q;

    // Three zero bits below the magnitude give right-padding of frac for small MSB positions
    always_comb begin
        mag_w  = buf_q[idx_q];
        ext_w  = {mag_w[22:0], 3'b000};
        msb_w  = 5'd0;
        frac_w = 3'd0;
        for (int i = 0; i < 24; i++) begin
            if (mag_w[i]) begin
                msb_w  = 5'(i);
                frac_w = ext_w[i+2 -: 3];
            end
        end
        level_w = (mag_w == 24'd0) ? 8'd0
                                   : (((8'(msb_w) + 8'd1) << 3) + 8'(frac_w));
        tgt_w   = (level_w > 8'(FLOOR)) ? (level_w - 8'(FLOOR)) : 8'd0;
        cur_w   = h_q[idx_q];
        dec_w   = (cur_w > 8'(DECAY)) ? (cur_w - 8'(DECAY)) : 8'd0;
        if (tgt_w >= cur_w) begin
            new_w = tgt_w;
        end else begin
            new_w = (dec_w > tgt_w) ? dec_w : tgt_w;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        capture_w = 1'b0;
        write_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_w) begin
                    capture_w = 1'b1;
                    idx_d     = 4'd0;
                    state_d   = PROC;
                end
            end
            PROC: begin
                write_w   = 1'b1;
                overrun_d = rise_w;
                if (idx_q == 4'd15) begin
                    valid_d = 1'b1;
                    idx_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 24'd0;
                h_q[i]   <= 8'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done;
            armed_q   <= 1'b1;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            if (capture_w) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[i] <= f_w[i];
                end
            end
            if (write_w) begin
                h_q[idx_q] <= new_w;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spectrum_bar_scaler.sv
// tb_spectrum_bar_scaler: table of consecutive frames with hand-computed bar heights
// (FLOOR=64, DECAY=2), plus sequences for decay, overrun, held done and mid-frame reset.
`default_nettype none

module tb_spectrum_bar_scaler;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              done;
    logic [15:0][23:0] fv;
    logic [15:0][7:0]  hv;
    logic              valid, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0][23:0] f;
        logic [15:0][7:0]  h;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    spectrum_bar_scaler #(.FLOOR(64), .DECAY(2)) dut (
        .clk(clk), .reset(rst_n), .done(done),
        .f0(fv[0]),   .f1(fv[1]),   .f2(fv[2]),   .f3(fv[3]),
        .f4(fv[4]),   .f5(fv[5]),   .f6(fv[6]),   .f7(fv[7]),
        .f8(fv[8]),   .f9(fv[9]),   .f10(fv[10]), .f11(fv[11]),
        .f12(fv[12]), .f13(fv[13]), .f14(fv[14]), .f15(fv[15]),
        .h0(hv[0]),   .h1(hv[1]),   .h2(hv[2]),   .h3(hv[3]),
        .h4(hv[4]),   .h5(hv[5]),   .h6(hv[6]),   .h7(hv[7]),
        .h8(hv[8]),   .h9(hv[9]),   .h10(hv[10]), .h11(hv[11]),
        .h12(hv[12]), .h13(hv[13]), .h14(hv[14]), .h15(hv[15]),
        .valid(valid), .busy(busy), .overrun(overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_h(input string tag, input logic [15:0][7:0] exp);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s h%0d", tag, i), 32'(hv[i]), 32'(exp[i]));
        end
    endtask

    // One done pulse; samples on negedges, k=0 is the cycle right after the capture edge
    task automatic run_frame(input logic [15:0][23:0] f_in, input string tag);
        int busy_n, valid_n, valid_at;
        busy_n = 0; valid_n = 0; valid_at = -1;
        @(negedge clk);
        fv   = f_in;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        fv   = {16{24'hA5C3F1}};
        for (int k = 0; k < 24; k++) begin
            if (busy) busy_n++;
            if (valid) begin
                valid_n++;
                valid_at = k;
            end
            if (k < 23) @(negedge clk);
        end
        check({tag, " busy cycles"}, busy_n, 16);
        check({tag, " valid count"}, valid_n, 1);
        check({tag, " valid position"}, valid_at, 16);
    endtask

    initial begin
        int exp1, ov_n, val_n, busy_n;

        for (int i = 0; i < 4; i++) tbl[i] = '0;
        // Frame A from cleared history
        tbl[0].f[0]  = 24'h000001;  tbl[0].h[0]  = 8'd0;
        tbl[0].f[1]  = 24'h800000;  tbl[0].h[1]  = 8'd128;
        tbl[0].f[2]  = 24'h000100;  tbl[0].h[2]  = 8'd8;
        tbl[0].f[3]  = 24'h0001C0;  tbl[0].h[3]  = 8'd14;
        tbl[0].f[4]  = 24'h000000;  tbl[0].h[4]  = 8'd0;
        tbl[0].f[5]  = 24'hFFFFFF;  tbl[0].h[5]  = 8'd135;
        tbl[0].f[6]  = 24'h000002;  tbl[0].h[6]  = 8'd0;
        tbl[0].f[7]  = 24'h000007;  tbl[0].h[7]  = 8'd0;
        tbl[0].f[8]  = 24'h0000FF;  tbl[0].h[8]  = 8'd7;
        tbl[0].f[9]  = 24'h000080;  tbl[0].h[9]  = 8'd0;
        tbl[0].f[10] = 24'h000090;  tbl[0].h[10] = 8'd1;
        tbl[0].f[11] = 24'h010000;  tbl[0].h[11] = 8'd72;
        tbl[0].f[12] = 24'h123456;  tbl[0].h[12] = 8'd105;
        tbl[0].f[13] = 24'h400000;  tbl[0].h[13] = 8'd120;
        tbl[0].f[14] = 24'h00F000;  tbl[0].h[14] = 8'd71;
        tbl[0].f[15] = 24'h000300;  tbl[0].h[15] = 8'd20;
        // Frame B: all zero inputs, every bar decays by 2 (saturating)
        tbl[1].h = {8'd18, 8'd69, 8'd118, 8'd103, 8'd70, 8'd0, 8'd0, 8'd5,
                    8'd0, 8'd0, 8'd133, 8'd0, 8'd12, 8'd6, 8'd126, 8'd0};
        // Frame C: instant rise, equal target, target below decayed value
        tbl[2].f[2]  = 24'h000100;
        tbl[2].f[3]  = 24'h000180;
        tbl[2].f[5]  = 24'h000100;
        tbl[2].f[8]  = 24'h0000FF;
        tbl[2].f[11] = 24'h008000;
        tbl[2].h = {8'd16, 8'd67, 8'd116, 8'd101, 8'd68, 8'd0, 8'd0, 8'd7,
                    8'd0, 8'd0, 8'd131, 8'd0, 8'd12, 8'd8, 8'd124, 8'd0};
        // Frame D: target clamps the decay (h2 8 -> 7)
        tbl[3].f[2]  = 24'h0000FF;
        tbl[3].h = {8'd14, 8'd65, 8'd114, 8'd99, 8'd66, 8'd0, 8'd0, 8'd5,
                    8'd0, 8'd0, 8'd129, 8'd0, 8'd10, 8'd7, 8'd122, 8'd0};

        // Reset with random inputs
        rst_n = 1'b0;
        done  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) fv[i] = 24'($urandom);
        repeat (3) @(negedge clk);
        check_h("reset", '0);
        check("reset valid", valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        done  = 1'b0;
        rst_n = 1'b1;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy || valid || overrun) busy_n++;
        end
        check("idle activity", busy_n, 0);
        check_h("idle", '0);

        for (int v = 0; v < 4; v++) begin
            run_frame(tbl[v].f, $sformatf("vec%0d", v));
            check_h($sformatf("vec%0d", v), tbl[v].h);
        end

        // Linear decay of bar 1 down to 2, instant rise, then decay to 0 and stay there
        exp1 = 32'(tbl[3].h[1]);
        for (int n = 0; n < 70 && exp1 > 2; n++) begin
            run_frame('0, "decay");
            exp1 = exp1 - 2;
            check("decay h1", hv[1], exp1);
        end
        fv = '0;
        fv[1] = 24'h000100;
        run_frame(fv, "rise");
        check("rise h1", hv[1], 8);
        exp1 = 8;
        for (int n = 0; n < 6; n++) begin
            run_frame('0, "tail");
            exp1 = (exp1 > 2) ? exp1 - 2 : 0;
            check("tail h1", hv[1], exp1);
        end

        // Clear history, then overrun: second done 5 cycles after the first is dropped
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fv   = tbl[0].f;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        ov_n = 0; val_n = 0;
        for (int k = 0; k < 30; k++) begin
            if (overrun) ov_n++;
            if (valid) val_n++;
            if (k == 5) done = 1'b1;
            if (k == 6) done = 1'b0;
            @(negedge clk);
        end
        check("overrun count", ov_n, 1);
        check("overrun valid count", val_n, 1);
        check_h("overrun", tbl[0].h);
        run_frame(tbl[1].f, "after_ovr");
        check_h("after_ovr", tbl[1].h);

        // Held done level: exactly one frame
        @(negedge clk);
        fv   = tbl[2].f;
        done = 1'b1;
        ov_n = 0; val_n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (overrun) ov_n++;
            if (valid) val_n++;
        end
        done = 1'b0;
        check("held valid count", val_n, 1);
        check("held overrun count", ov_n, 0);
        check_h("held", tbl[2].h);

        // Reset after E8 of a frame, released with done high
        @(negedge clk);
        fv   = tbl[3].f;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_h("midreset", '0);
        check("midreset busy", busy, 0);
        check("midreset valid", valid, 0);
        done = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy || valid) busy_n++;
        end
        check("release with done high", busy_n, 0);
        done = 1'b0;
        @(negedge clk);
        run_frame(tbl[0].f, "fresh");
        check_h("fresh", tbl[0].h);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
